// File: rtl/pll_pkg.sv
// rtl/pll_pkg.sv - shared state encoding and cycle-count defaults for the PLL sequencer
package pll_pkg;

  typedef enum logic [2:0] {
    OSC_IDLE,
    GUARD_OUT,
    DISABLE,
    APPLY,
    SETTLE,
    GUARD_IN,
    RUN
  } pll_state_t;

  localparam int DEF_DIS_CYCLES    = 16;
  localparam int DEF_SETTLE_CYCLES = 4096;
  localparam int DEF_GUARD_CYCLES  = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// rtl/seq_timer.sv - loadable down-counter; done is high in the last cycle of a loaded interval
module seq_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  // Loaded with N on state entry, so a count of 1 marks the Nth cycle of the state.
  assign done = (count == WIDTH'(1));

endmodule

// File: rtl/pll_sequencer.sv
// rtl/pll_sequencer.sv - sequences PLL disable/apply/settle and glitch-free core clock switchover
module pll_sequencer
  import pll_pkg::*;
#(
  parameter int DIS_CYCLES    = DEF_DIS_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int GUARD_CYCLES  = DEF_GUARD_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic        cfg_enable,
  input  logic        cfg_dco,
  input  logic [4:0]  cfg_div,
  input  logic [25:0] cfg_trim,
  output logic        pll_enable,
  output logic        pll_reset_n,
  output logic        pll_dco,
  output logic [4:0]  pll_div,
  output logic [25:0] pll_ext_trim,
  output logic        clk_sel,
  output logic        busy,
  output logic        cfg_err
);

  localparam int TW = $clog2(max3(DIS_CYCLES, SETTLE_CYCLES, GUARD_CYCLES) + 1);

  pll_state_t    state;
  logic          cap_enable;
  logic          cap_dco;
  logic [4:0]    cap_div;
  logic [25:0]   cap_trim;
  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_done;
  logic          handshake;
  logic          bad_req;

  assign cfg_ready = (state == OSC_IDLE) || (state == RUN);
  assign busy      = ~cfg_ready;
  assign handshake = cfg_valid && cfg_ready;
  // Integer-N mode cannot lock with a feedback divide below 2.
  assign bad_req   = cfg_enable && !cfg_dco && (cfg_div < 5'd2);

  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state)
      OSC_IDLE:  if (handshake && !bad_req) begin tmr_load = 1'b1; tmr_value = TW'(DIS_CYCLES);    end
      RUN:       if (handshake && !bad_req) begin tmr_load = 1'b1; tmr_value = TW'(GUARD_CYCLES);  end
      GUARD_OUT: if (tmr_done)              begin tmr_load = 1'b1; tmr_value = TW'(DIS_CYCLES);    end
      APPLY:     if (cap_enable)            begin tmr_load = 1'b1; tmr_value = TW'(SETTLE_CYCLES); end
      SETTLE:    if (tmr_done)              begin tmr_load = 1'b1; tmr_value = TW'(GUARD_CYCLES);  end
      default: ;
    endcase
  end

  seq_timer #(.WIDTH(TW)) u_timer (
    .clock (clock),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= OSC_IDLE;
      clk_sel      <= 1'b0;
      pll_enable   <= 1'b0;
      pll_reset_n  <= 1'b0;
      pll_dco      <= 1'b1;
      pll_div      <= '0;
      pll_ext_trim <= '0;
      cfg_err      <= 1'b0;
      cap_enable   <= 1'b0;
      cap_dco      <= 1'b1;
      cap_div      <= '0;
      cap_trim     <= '0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        OSC_IDLE, RUN: begin
          if (handshake) begin
            if (bad_req) begin
              cfg_err <= 1'b1;
            end else begin
              cap_enable <= cfg_enable;
              cap_dco    <= cfg_dco;
              cap_div    <= cfg_div;
              cap_trim   <= cfg_trim;
              if (state == RUN) begin
                state   <= GUARD_OUT;
                clk_sel <= 1'b0;
              end else begin
                state       <= DISABLE;
                pll_enable  <= 1'b0;
                pll_reset_n <= 1'b0;
              end
            end
          end
        end
        GUARD_OUT: begin
          if (tmr_done) begin
            state       <= DISABLE;
            pll_enable  <= 1'b0;
            pll_reset_n <= 1'b0;
          end
        end
        DISABLE: begin
          if (tmr_done) begin
            state        <= APPLY;
            pll_dco      <= cap_dco;
            pll_div      <= cap_div;
            pll_ext_trim <= cap_trim;
          end
        end
        APPLY: begin
          if (cap_enable) begin
            state       <= SETTLE;
            pll_enable  <= 1'b1;
            pll_reset_n <= 1'b1;
          end else begin
            state <= OSC_IDLE;
          end
        end
        SETTLE: begin
          if (tmr_done) state <= GUARD_IN;
        end
        GUARD_IN: begin
          if (tmr_done) begin
            state   <= RUN;
            clk_sel <= 1'b1;
          end
        end
        default: state <= OSC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_sequencer.sv
// tb/tb_pll_sequencer.sv - scoreboard bench: request model predicts phase lengths and final PLL settings
module tb_pll_sequencer;

  localparam int DIS = 5;
  localparam int SET = 150;
  localparam int GRD = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic        cfg_enable = 1'b0;
  logic        cfg_dco = 1'b0;
  logic [4:0]  cfg_div = '0;
  logic [25:0] cfg_trim = '0;
  logic        pll_enable;
  logic        pll_reset_n;
  logic        pll_dco;
  logic [4:0]  pll_div;
  logic [25:0] pll_ext_trim;
  logic        clk_sel;
  logic        busy;
  logic        cfg_err;

  always #5 clock = ~clock;

  pll_sequencer #(
    .DIS_CYCLES    (DIS),
    .SETTLE_CYCLES (SET),
    .GUARD_CYCLES  (GRD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_enable   (cfg_enable),
    .cfg_dco      (cfg_dco),
    .cfg_div      (cfg_div),
    .cfg_trim     (cfg_trim),
    .pll_enable   (pll_enable),
    .pll_reset_n  (pll_reset_n),
    .pll_dco      (pll_dco),
    .pll_div      (pll_div),
    .pll_ext_trim (pll_ext_trim),
    .clk_sel      (clk_sel),
    .busy         (busy),
    .cfg_err      (cfg_err)
  );

  typedef struct {
    bit          is_reject;
    int          guard_out;
    int          dis;
    int          settle_guard;
    logic [4:0]  old_div;
    logic        en;
    logic        dco;
    logic [4:0]  div;
    logic [25:0] trim;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  bit          m_run;
  logic        m_dco;
  logic [4:0]  m_div;
  logic [25:0] m_trim;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_dco  = 1'b1;
    m_div  = '0;
    m_trim = '0;
    exp_q.delete();
  endtask

  task automatic model_request(input logic en, input logic dco, input logic [4:0] div, input logic [25:0] trim);
    exp_t e;
    if (en && !dco && div < 2) begin
      e = '{1'b1, 0, 0, 0, m_div, m_run, m_dco, m_div, m_trim};
    end else begin
      e = '{1'b0, m_run ? GRD : 0, DIS + 1, en ? SET + GRD : 0, m_div, en, dco, div, trim};
      m_run  = en;
      m_dco  = dco;
      m_div  = div;
      m_trim = trim;
    end
    exp_q.push_back(e);
  endtask

  task automatic send(input logic en, input logic dco, input logic [4:0] div, input logic [25:0] trim, input bit jitter);
    int n = 0;
    @(negedge clock);
    cfg_valid  = 1'b1;
    cfg_enable = en;
    cfg_dco    = dco;
    cfg_div    = div;
    cfg_trim   = trim;
    while (!cfg_ready && n < 2000) begin
      if (jitter) cfg_div = 5'($urandom_range(2, 31));
      @(negedge clock);
      n++;
    end
    check("cfg_ready_wait", cfg_ready, 1);
    if (cfg_ready) begin
      model_request(cfg_enable, cfg_dco, cfg_div, cfg_trim);
      @(posedge clock);
    end
    #1 cfg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (busy && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check("idle_wait", busy, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_clk_sel"}, clk_sel, 0);
    check({tag, "_pll_enable"}, pll_enable, 0);
    check({tag, "_pll_reset_n"}, pll_reset_n, 0);
    check({tag, "_pll_dco"}, pll_dco, 1);
    check({tag, "_pll_ext_trim"}, pll_ext_trim, 0);
    check({tag, "_pll_div"}, pll_div, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cfg_ready"}, cfg_ready, 1);
  endtask

  // Monitor: measures each busy stretch by phase and pops the prediction when it ends.
  bit         prev_busy = 1'b0;
  int         go_cnt, dis_cnt, sg_cnt, clk_hi;
  logic [4:0] first_div, last_div;

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      prev_busy = 1'b0;
      exp_q.delete();
    end else begin
      if (busy && !prev_busy) begin
        go_cnt = 0; dis_cnt = 0; sg_cnt = 0; clk_hi = 0;
      end
      if (busy) begin
        if (!pll_enable) begin
          if (dis_cnt == 0) first_div = pll_div;
          last_div = pll_div;
          dis_cnt++;
        end else if (dis_cnt == 0) begin
          go_cnt++;
        end else begin
          sg_cnt++;
        end
        if (clk_sel) clk_hi++;
      end
      if (cfg_err) begin
        check("err_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("err_kind", e.is_reject, 1);
          check("err_cfg_ready", cfg_ready, 1);
          check("err_pll_enable", pll_enable, e.en);
          check("err_clk_sel", clk_sel, e.en);
          check("err_pll_div", pll_div, e.div);
          check("err_pll_dco", pll_dco, e.dco);
          check("err_pll_trim", pll_ext_trim, e.trim);
        end
      end
      if (!busy && prev_busy) begin
        check("done_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("done_kind", e.is_reject, 0);
          check("guard_out_cycles", go_cnt, e.guard_out);
          check("disable_apply_cycles", dis_cnt, e.dis);
          check("settle_guard_in_cycles", sg_cnt, e.settle_guard);
          check("clk_sel_high_while_busy", clk_hi, 0);
          check("div_before_apply", first_div, e.old_div);
          check("div_in_apply", last_div, e.div);
          check("final_pll_enable", pll_enable, e.en);
          check("final_pll_reset_n", pll_reset_n, e.en);
          check("final_clk_sel", clk_sel, e.en);
          check("final_pll_dco", pll_dco, e.dco);
          check("final_pll_div", pll_div, e.div);
          check("final_pll_trim", pll_ext_trim, e.trim);
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_vals("rst_init");
    reset = 1'b0;

    send(1'b1, 1'b0, 5'd8, 26'($urandom), 1'b0);
    wait_idle();
    send(1'b1, 1'b0, 5'd12, 26'($urandom), 1'b0);
    wait_idle();

    send(1'b0, 1'b1, 5'd5, 26'($urandom), 1'b0);
    wait_idle();
    send(1'b1, 1'b0, 5'd1, 26'($urandom), 1'b0);
    repeat (2) @(negedge clock);
    check("reject_ready_held", cfg_ready, 1);

    send(1'b1, 1'b0, 5'd9, 26'($urandom), 1'b0);
    send(1'b0, 1'b1, 5'($urandom), 26'h3FFFFFF, 1'b0);
    wait_idle();

    send(1'b1, 1'b0, 5'd10, 26'($urandom), 1'b0);
    n = 0;
    while (!pll_enable && n < 500) begin
      @(negedge clock);
      n++;
    end
    check("settle_start", pll_enable, 1);
    repeat (99) @(negedge clock);
    check("mid_settle_busy", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    check_reset_vals("rst_settle");
    reset = 1'b0;
    model_reset();
    send(1'b1, 1'b1, 5'd3, 26'($urandom), 1'b0);
    wait_idle();

    send(1'b1, 1'b0, 5'd7, 26'($urandom), 1'b0);
    send(1'b1, 1'b1, 5'd3, 26'($urandom), 1'b1);
    wait_idle();

    for (int i = 0; i < 14; i++) begin
      send(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           (i % 5 == 0) ? 5'($urandom_range(0, 1)) : 5'($urandom_range(0, 31)),
           26'($urandom), 1'($urandom_range(0, 1)));
    end
    wait_idle();
    repeat (3) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_sequencer.md
PLL_SEQUENCER -- requirements
Module: pll_sequencer

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-002 Parameter DIS_CYCLES, default 16: clocks the PLL is held disabled before new settings are applied.
REQ-003 Parameter SETTLE_CYCLES, default 4096: clocks allowed for the loop to settle after enable.
REQ-004 Parameter GUARD_CYCLES, default 8: quiet clocks before and after every clock-select change.
REQ-005 Ports (name, direction, width, meaning):
- clock  in  1  reference oscillator clock; never the PLL output.
- reset  in  1  synchronous, active-high.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  request accepted when cfg_valid and cfg_ready are both high.
- cfg_enable  in  1  PLL requested on (1) or off (0).
- cfg_dco  in  1  DCO mode.
- cfg_div  in  5  feedback divide ratio.
- cfg_trim  in  26  DCO trim word.
- pll_enable  out  1  to the PLL enable input.
- pll_reset_n  out  1  to the PLL reset_n input.
- pll_dco  out  1  to the PLL dco input.
- pll_div  out  5  to the PLL div input.
- pll_ext_trim  out  26  to the PLL ext_trim input.
- clk_sel  out  1  core clock select: 0 = oscillator, 1 = PLL.
- busy  out  1  sequence in progress.
- cfg_err  out  1  one-cycle pulse when a request is rejected.

Function
REQ-006 The state machine SHALL have these states: OSC_IDLE, GUARD_OUT, DISABLE, APPLY, SETTLE, GUARD_IN, RUN.
REQ-007 cfg_ready SHALL be 1 only in OSC_IDLE and RUN, and busy SHALL equal NOT cfg_ready.
REQ-008 An accepted request SHALL be rejected, with a cfg_err pulse on the next cycle and no state change, when cfg_enable=1, cfg_dco=0 and cfg_div<2.
REQ-009 A valid request accepted in RUN SHALL go to GUARD_OUT, where clk_sel=0 is driven in the first cycle and held for GUARD_CYCLES.
REQ-010 A valid request accepted in OSC_IDLE SHALL go directly to DISABLE.
REQ-011 DISABLE SHALL drive pll_enable=0 and pll_reset_n=0 for DIS_CYCLES.
REQ-012 APPLY SHALL be a single cycle in which cfg_dco, cfg_div and cfg_trim are registered onto pll_dco, pll_div and pll_ext_trim.
- The configuration SHALL be captured on the handshake cycle.
- The pll_* configuration outputs SHALL change only in APPLY.
REQ-013 From APPLY, the next state SHALL be SETTLE if the captured enable is 1, else OSC_IDLE.
REQ-014 SETTLE SHALL drive pll_enable=1 and pll_reset_n=1 and count SETTLE_CYCLES, then go to GUARD_IN.
REQ-015 GUARD_IN SHALL count GUARD_CYCLES, then set clk_sel=1 and enter RUN.
REQ-016 clk_sel SHALL rise only on the GUARD_IN-to-RUN transition and fall only on entry to GUARD_OUT, or on reset.
REQ-017 pll_enable and pll_reset_n SHALL remain 1 throughout GUARD_IN, RUN and GUARD_OUT.
REQ-018 A request with cfg_enable=0 accepted in OSC_IDLE SHALL still pass through DISABLE and APPLY, so trim and div are updated, and return to OSC_IDLE.
REQ-019 cfg_valid while busy SHALL be ignored and not queued; the requester holds it until cfg_ready.
REQ-020 The single down-counter SHALL be sized for max(DIS_CYCLES, SETTLE_CYCLES, GUARD_CYCLES).
- It SHALL be loaded on each state entry.
- A state SHALL last exactly its parameter count of cycles, so a value of 1 gives one cycle.

Reset
REQ-021 On reset the block SHALL enter OSC_IDLE with the following outputs:
- clk_sel=0, pll_enable=0, pll_reset_n=0.
- pll_dco=1 and pll_ext_trim=0, which keeps the PLL controller in reset.
- pll_div=0, cfg_err=0, busy=0, cfg_ready=1.
REQ-022 Reset asserted in any state, including mid-SETTLE, SHALL take effect at the next clock edge with no guard sequence; clk_sel falls immediately.

Structure
REQ-023 The state enumeration and the default values of the three cycle-count parameters SHALL reside in the shared package pll_pkg.
REQ-024 The counter SHALL be the sub-module seq_timer (load, value, done); everything else SHALL be a single flat FSM.

Verification
REQ-025 Reset, then request enable=1, dco=0, div=8:
- DIS_CYCLES cycles of pll_enable=0, then APPLY.
- pll_div=8 appears in APPLY.
- clk_sel=1 exactly SETTLE_CYCLES+GUARD_CYCLES cycles after APPLY.
REQ-026 In RUN, request div=12: clk_sel=0 the cycle after the handshake and for GUARD_CYCLES before pll_enable falls; clk_sel returns to 1 after the full sequence.
REQ-027 Request enable=1, dco=0, div=1 in OSC_IDLE: cfg_err pulses once, state and all pll_* outputs are unchanged, and cfg_ready stays 1.
REQ-028 In RUN, request enable=0, dco=1, trim=26'h3FFFFFF: the block ends in OSC_IDLE with pll_enable=0, pll_ext_trim=26'h3FFFFFF and clk_sel=0.
REQ-029 Assert reset in SETTLE cycle 100: the next cycle shows OSC_IDLE with all reset values, and a following request completes normally.
REQ-030 Hold cfg_valid throughout busy with changing cfg_div: only the value present on the cfg_ready handshake cycle reaches pll_div.
